// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte scheduler in front of a single uart_transmit
//
// Purpose:
//   Lets NUM_REQ on-chip byte producers share one uart_transmit instance.
//   Each requester offers a byte over a valid/ready handshake; one byte is
//   accepted per grant, picked round-robin. The accepted byte is handed to
//   uart_transmit with a one-cycle dataReady pulse. Because uart_transmit has
//   no busy output, the frame length is timed locally before the next grant.
//
// Ports:
//   clock          in   single clock domain
//   reset          in   synchronous, active-high
//   enable         in   1 = new grants allowed; a frame in flight always completes
//   req_valid      in   [NUM_REQ]    requester i offers req_data[8*i+:8]
//   req_data       in   [8*NUM_REQ]  packed requester bytes
//   req_ready      out  [NUM_REQ]    one-hot accept strobe, only ever high in IDLE
//   tx_data_ready  out  one-cycle pulse to uart_transmit.dataReady
//   tx_data_in     out  [8] byte to uart_transmit.dataIn, held through the frame
//   busy           out  high in every state except IDLE
//   grant_id       out  index of the last granted requester
//   frame_done     out  one-cycle pulse on the last cycle of the frame

module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 521,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_data_ready,
  output logic [7:0]                 tx_data_in,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);

  localparam int ID_W         = $clog2(NUM_REQ);
  localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
  localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int GAP_W        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0]  RR_INIT  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] frame_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [ID_W-1:0]  rr_last;

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid requester starting one past the last grant.
  // rr_last resets to NUM_REQ-1 so requester 0 is searched first.
  // ---------------------------------------------------------------------------
  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [7:0]      win_data;
  logic [ID_W-1:0] probe;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    probe     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      probe = ID_W'((int'(rr_last) + k) % NUM_REQ);
      if (!win_found && req_valid[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
        win_data  = req_data[{probe, 3'b000} +: 8];
      end
    end
  end

  // A grant is only offered while reset is low: a handshake completed on a
  // reset edge would be silently discarded, so the requester must not see it.
  logic take;
  assign take = (state == IDLE) && enable && win_found && !reset;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    req_ready     = '0;
    tx_data_ready = 1'b0;
    busy          = 1'b1;
    frame_done    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (take) begin
          req_ready[win_idx] = 1'b1;
          state_next         = LOAD;
        end
      end
      LOAD: begin
        tx_data_ready = 1'b1;
        state_next    = SEND;
      end
      SEND: begin
        // enable is deliberately ignored here: a started frame always runs out.
        if (frame_cnt == CNT_LAST) begin
          frame_done = 1'b1;
          state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: captured byte, grant bookkeeping and the frame/gap timers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_data_in <= '0;
      grant_id   <= '0;
      rr_last    <= RR_INIT;
    end else if (take) begin
      tx_data_in <= win_data;
      grant_id   <= win_idx;
      rr_last    <= win_idx;
    end
  end

  // Counters sit at zero outside their state, so entering SEND or GAP always
  // starts a fresh count and the frame counter never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      if (state == SEND && frame_cnt != CNT_LAST) begin
        frame_cnt <= frame_cnt + 1'b1;
      end else begin
        frame_cnt <= '0;
      end
      if (state == GAP && gap_cnt != GAP_LAST) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  localparam int NR    = 4;
  localparam int CPB   = 4;
  localparam int FB    = 10;
  localparam int FRAME = CPB * FB;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            tx_data_ready;
  logic [7:0]      tx_data_in;
  logic            busy;
  logic [1:0]      grant_id;
  logic            frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int model_last;

  uart_tx_scheduler #(
    .NUM_REQ(NR), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GAP_CYCLES(0)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data_ready(tx_data_ready), .tx_data_in(tx_data_in), .busy(busy),
    .grant_id(grant_id), .frame_done(frame_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  // ---------------- bench-side uart_transmit stand-in and receiver ----------
  logic ser_active = 1'b0;
  int   ser_cnt    = 0;
  logic line;

  always @(posedge clock) begin
    if (reset) ser_active <= 1'b0;
    else if (tx_data_ready) begin ser_active <= 1'b1; ser_cnt <= 0; end
    else if (ser_active) begin
      if (ser_cnt == FRAME - 1) ser_active <= 1'b0;
      else ser_cnt <= ser_cnt + 1;
    end
  end

  // tx_data_in is read live every bit, so any instability during the frame
  // corrupts the received byte.
  always_comb begin
    line = 1'b1;
    if (ser_active) begin
      if (ser_cnt < CPB) line = 1'b0;
      else if (ser_cnt < 9 * CPB) line = tx_data_in[ser_cnt / CPB - 1];
    end
  end

  logic       rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_sh     = 8'h00;
  int         rx_err    = 0;
  logic [7:0] rx_q[$];

  always @(posedge clock) begin
    if (reset) rx_active <= 1'b0;
    else if (!rx_active) begin
      if (!line) begin rx_active <= 1'b1; rx_cnt <= 1; end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
        rx_sh[rx_cnt / CPB - 1] <= line;
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        rx_active <= 1'b0;
        if (line) rx_q.push_back(rx_sh);
        else rx_err <= rx_err + 1;
      end
    end
  end

  // ---------------- whole-run handshake invariants ---------------------------
  always @(negedge clock) begin
    if (!reset) begin
      n_checks++;
      assert (!(busy && (req_ready != '0)) && $onehot0(req_ready)) n_pass++;
      else $error("FAIL ready_only_in_idle: req_ready=%b busy=%b required onehot0 and idle", req_ready, busy);
    end
  end

  // ---------------- helpers --------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 200) begin tick(); k++; end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_last = NR - 1;
  endtask

  // Reference arbitration rule: first valid index searching from last+1.
  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    rr_pick = -1;
    for (int k = 1; k <= NR; k++)
      if (rr_pick < 0 && v[(last + k) % NR]) rr_pick = (last + k) % NR;
  endfunction

  // ---------------- directed + randomized sequence ---------------------------
  int          bad, k, w, np;
  int          g_q[$];
  int          p_q[$];
  int          d_q[$];
  logic [NR-1:0] rv, snap;
  logic [31:0] rd;
  logic        ren;

  initial begin
    reset = 1'b1; enable = 1'b1; req_valid = '0; req_data = '0;
    repeat (3) tick();
    check("rst_ready", req_ready, 0);
    check("rst_pulse", tx_data_ready, 0);
    check("rst_data", tx_data_in, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_done", frame_done, 0);
    reset = 1'b0;
    model_last = NR - 1;

    // 1: single request, latency and frame length
    req_valid = 4'b0100; req_data = 32'h00A5_0000;
    #1;
    w = rr_pick(req_valid, model_last);
    check("t1_ready", req_ready, 32'd1 << w);
    tick();
    req_valid = '0; model_last = w;
    check("t1_pulse", tx_data_ready, 1);
    check("t1_data", tx_data_in, 8'hA5);
    check("t1_grant", grant_id, 2);
    bad = 0;
    for (int i = 1; i <= FRAME; i++) begin
      tick();
      if (i < FRAME && frame_done) bad++;
      if (i == FRAME) check("t1_done_at_40", frame_done, 1);
    end
    check("t1_no_early_done", bad, 0);
    tick();
    check("t1_idle_after", busy, 0);

    // 2: all four requesting continuously
    do_reset();
    req_data = 32'h1312_1110; req_valid = 4'hF;
    g_q.delete(); p_q.delete(); d_q.delete();
    np = 0;
    for (int c = 0; c < 300 && np < 5; c++) begin
      #1;
      for (int i = 0; i < NR; i++) if (req_ready[i]) g_q.push_back(i);
      tick();
      if (tx_data_ready) begin p_q.push_back(cyc); d_q.push_back(int'(tx_data_in)); np++; end
    end
    req_valid = '0;
    check("t2_pulse_count", p_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      w = rr_pick(4'hF, model_last);
      model_last = w;
      check($sformatf("t2_grant%0d", i), g_q[i], w);
      check($sformatf("t2_byte%0d", i), d_q[i], 32'h10 + w);
    end
    for (int i = 1; i < 5; i++)
      check($sformatf("t2_spacing%0d", i), p_q[i] - p_q[i-1], 42);
    wait_idle("t2_idle");

    // 3: enable low holds off grants; enable falling mid-frame does not cut it
    enable = 1'b0; req_valid = 4'b0010; req_data = 32'h0000_7E00;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (req_ready != '0 || tx_data_ready) bad++;
      tick();
    end
    check("t3_quiet", bad, 0);
    enable = 1'b1;
    #1;
    check("t3_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0; model_last = 1; enable = 1'b0;
    check("t3_pulse", tx_data_ready, 1);
    check("t3_grant", grant_id, 1);
    check("t3_data", tx_data_in, 8'h7E);
    k = 0;
    while (!frame_done && k < 60) begin tick(); k++; end
    check("t3_frame_len", k, FRAME);
    tick();
    check("t3_idle", busy, 0);
    enable = 1'b1;

    // 4: reset in the middle of SEND
    req_valid = 4'b0001; req_data = 32'h0000_00C3;
    #1;
    w = rr_pick(req_valid, model_last);
    check("t4_ready0", req_ready, 32'd1 << w);
    tick();
    req_valid = '0; model_last = w;
    check("t4_pulse0", tx_data_ready, 1);
    repeat (20) tick();
    reset = 1'b1; req_valid = 4'b1000; req_data = 32'h5A00_0000;
    tick();
    check("t4_rst_ready", req_ready, 0);
    check("t4_rst_pulse", tx_data_ready, 0);
    check("t4_rst_data", tx_data_in, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_grant", grant_id, 0);
    check("t4_rst_done", frame_done, 0);
    reset = 1'b0; model_last = NR - 1;
    #1;
    w = rr_pick(req_valid, model_last);
    check("t4_ready3", req_ready, 32'd1 << w);
    tick();
    req_valid = '0; model_last = w;
    check("t4_pulse3", tx_data_ready, 1);
    check("t4_grant3", grant_id, 3);
    check("t4_data3", tx_data_in, 8'h5A);

    // 5: valid pulsed only during SEND is never granted
    repeat (5) tick();
    req_valid = 4'b0010; req_data = 32'h0000_9900;
    #1;
    check("t5_no_ready", req_ready, 0);
    tick();
    req_valid = '0;
    wait_idle("t5_idle");
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready != '0 || tx_data_ready) bad++;
      tick();
    end
    check("t5_no_grant", bad, 0);

    // randomized: arbitration and captured byte against the reference rule
    for (int it = 0; it < 12; it++) begin
      wait_idle($sformatf("rnd_idle%0d", it));
      rv  = 4'($urandom_range(0, 15));
      rd  = $urandom;
      ren = ($urandom_range(0, 3) != 0);
      req_valid = rv; req_data = rd; enable = ren;
      #1;
      w = ren ? rr_pick(rv, model_last) : -1;
      check($sformatf("rnd_ready%0d", it), req_ready, (w < 0) ? 32'd0 : (32'd1 << w));
      tick();
      req_valid = '0; enable = 1'b1;
      if (w >= 0) begin
        model_last = w;
        check($sformatf("rnd_data%0d", it), tx_data_in, rd[8*w +: 8]);
        check($sformatf("rnd_grant%0d", it), grant_id, w);
      end else begin
        check($sformatf("rnd_nopulse%0d", it), tx_data_ready, 0);
      end
    end

    // 6: end-to-end through the serial line
    wait_idle("t6_pre_idle");
    do_reset();
    rx_q.delete(); rx_err = 0;
    g_q.delete();
    req_data = 32'h0000_0055; req_valid = 4'b1001;
    for (int c = 0; c < 200 && g_q.size() < 2; c++) begin
      #1;
      snap = req_ready;
      tick();
      for (int i = 0; i < NR; i++) if (snap[i]) g_q.push_back(i);
      req_valid = req_valid & ~snap;
    end
    for (int c = 0; c < 200 && rx_q.size() < 2; c++) tick();
    check("t6_grants", g_q.size(), 2);
    check("t6_first_id", g_q[0], 0);
    check("t6_second_id", g_q[1], 3);
    check("t6_rx_count", rx_q.size(), 2);
    check("t6_rx0", rx_q[0], 8'h55);
    check("t6_rx1", rx_q[1], 8'h00);
    check("t6_rx_framing", rx_err, 0);
    repeat (60) tick();
    check("t6_no_dup", rx_q.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
